snitch_barrier_client: RTL
==========================

// Module: snitch_barrier_client
// PURPOSE
// Per-core initiator side of the cluster hardware barrier. Turns a core's barrier access
// (valid/ready request, valid/ready response) into a single-cycle arrival pulse toward the
// cluster barrier hub. Holds the core's response until the hub's one-cycle release pulse.
// One instance per core; barrier_o of all instances forms the hub's per-core arrival vector.
// PARAMETERS
// IdWidth       4   width of transaction ID echoed from request to response
// EpochWidth    16  width of release (epoch) counter returned in rsp_data_o
// TimeoutCycles 0   max WAIT cycles before error response; 0 = timeout disabled
// PORTS
// clk_i        in   1           clock
// rst_ni       in   1           asynchronous active-low reset
// req_valid_i  in   1           core requests barrier
// req_ready_o  out  1           request accepted when valid & ready
// req_id_i     in   IdWidth     ID of request
// rsp_valid_o  out  1           response available
// rsp_ready_i  in   1           core consumes response
// rsp_id_o     out  IdWidth     ID of the request being answered
// rsp_data_o   out  EpochWidth  epoch count after the release (zero-extended)
// rsp_error_o  out  1           1 = barrier timed out, no release seen
// barrier_o    out  1           arrival pulse to hub (exactly one cycle per arrival)
// barrier_i    in   1           release pulse from hub (one cycle, all cores arrived)
// BEHAVIOUR
// - Clock clk_i; reset rst_ni is asynchronous, active-low. Reset: state IDLE, all outputs 0,
//   epoch_q=0, orphan_q=0, timer=0. Reset mid-operation discards pending request/response.
// - FSM IDLE -> ARRIVE -> WAIT -> RESP -> IDLE.
//   IDLE:   req_ready_o=1. On accept: latch req_id_i; go ARRIVE (or WAIT if orphan_q=1 after
//           the release update below; arrival already registered at hub, no new pulse).
//   ARRIVE: barrier_o=1 for this cycle only; go WAIT; timer cleared.
//   WAIT:   on barrier_i: epoch_q+=1, rsp_error=0, go RESP. Else if TimeoutCycles!=0 and
//           timer==TimeoutCycles-1: rsp_error=1, orphan_q<=1, go RESP. Else timer+=1.
//   RESP:   rsp_valid_o=1; rsp_id/data/error stable until rsp_ready_i; on handshake -> IDLE.
// - barrier_o never high two consecutive cycles; never high in IDLE/WAIT/RESP.
//   Hub would re-arrive on a held level, and drops an arrival coinciding with its release.
// - Latency: accept at cycle T -> barrier_o at T+1; release seen at cycle R in WAIT ->
//   rsp_valid_o at R+1. Minimum accept-to-response for last arriving core: 3 cycles.
// - Every barrier_i pulse increments epoch_q (wraps modulo 2^EpochWidth), in any state.
// - barrier_i outside WAIT: if orphan_q=1, clear orphan_q (stale arrival consumed); else
//   ignored apart from epoch increment. Release and accept in the same IDLE cycle: release
//   clears orphan_q first, request then proceeds to ARRIVE (fresh arrival).
// - rsp_data_o = epoch_q value after the increment of the releasing pulse; on timeout,
//   current epoch_q.
// - Timer saturates; unused when TimeoutCycles=0 (WAIT is unbounded).
// - Back-pressure: core stalling in RESP does not lose releases (epoch still counts); a
//   release during RESP is not associated with a request.
// TESTING
// 1 Single client, hub pulses barrier_i 1 cycle after barrier_o -> barrier_o exactly 1 cycle,
//   rsp_valid_o 1 cycle after release, rsp_data_o=1, rsp_id_o=req_id, rsp_error_o=0.
// 2 8 clients + real hub, cores arrive at cycles 0..7 -> all rsp_valid_o same cycle, each
//   rsp_data_o=1; repeat 3 barriers -> data 2, 3; barrier_o count per client = 3.
// 3 TimeoutCycles=16, no release -> rsp_error_o=1 at 17 cycles after ARRIVE, orphan_q=1.
//   Next request -> no barrier_o pulse; release -> rsp_error_o=0.
// 4 rsp_ready_i low 10 cycles in RESP with barrier_i pulse inside -> outputs stable,
//   req_ready_o=0, epoch increments by 1; next barrier returns the incremented epoch.
// 5 EpochWidth=4, 16 releases -> rsp_data_o wraps to 0.
// 6 rst_ni low in WAIT and RESP, asynchronous (mid-cycle) -> outputs 0 immediately, IDLE.

Source files
------------

// File: rtl/snitch_barrier_client_if.sv
// Core-side barrier access bundle.
// Request and response valid/ready channels between a core and its barrier client.
interface snitch_barrier_client_if #(
   parameter int unsigned IdWidth    = 4,
   parameter int unsigned EpochWidth = 16
);
   logic                  req_valid;
   logic                  req_ready;
   logic [IdWidth-1:0]    req_id;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [IdWidth-1:0]    rsp_id;
   logic [EpochWidth-1:0] rsp_data;
   logic                  rsp_error;

   modport master (
      output req_valid, req_id, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_error
   );

   modport slave (
      input  req_valid, req_id, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_data, rsp_error
   );
endinterface

// File: rtl/snitch_barrier_client.sv
// Per-core barrier initiator: one arrival pulse per request toward the hub,
// response held until the hub's release pulse (or an optional timeout).
module snitch_barrier_client #(
   parameter int unsigned IdWidth       = 4,
   parameter int unsigned EpochWidth    = 16,
   parameter int unsigned TimeoutCycles = 0
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   snitch_barrier_client_if.slave  core,
   output logic                    barrier_o,
   input  logic                    barrier_i
);

   localparam int unsigned TimerW =
      (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
   localparam logic [TimerW-1:0] TimerLast =
      TimerW'((TimeoutCycles == 0) ? 0 : TimeoutCycles - 1);

   typedef enum logic [1:0] {
      StIdle,
      StArrive,
      StWait,
      StResp
   } state_e;

   state_e                state_q, state_d;
   logic [IdWidth-1:0]    id_q, id_d;
   logic [EpochWidth-1:0] data_q, data_d;
   logic                  err_q, err_d;
   logic [EpochWidth-1:0] epoch_q, epoch_d;
   logic                  orphan_q, orphan_d;
   logic [TimerW-1:0]     timer_q, timer_d;
   logic                  timeout_hit;

   assign timeout_hit = (TimeoutCycles != 0) && (timer_q == TimerLast);

   // State and datapath registers, async cleared
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= StIdle;
         id_q     <= '0;
         data_q   <= '0;
         err_q    <= 1'b0;
         epoch_q  <= '0;
         orphan_q <= 1'b0;
         timer_q  <= '0;
      end else begin
         state_q  <= state_d;
         id_q     <= id_d;
         data_q   <= data_d;
         err_q    <= err_d;
         epoch_q  <= epoch_d;
         orphan_q <= orphan_d;
         timer_q  <= timer_d;
      end
   end

   // Next state: every release bumps the epoch; a release outside WAIT
   // consumes a stale (timed-out) arrival still registered at the hub
   always_comb begin
      state_d  = state_q;
      id_d     = id_q;
      data_d   = data_q;
      err_d    = err_q;
      epoch_d  = epoch_q + EpochWidth'(barrier_i);
      orphan_d = orphan_q;
      timer_d  = '0;
      if (barrier_i && (state_q != StWait)) begin
         orphan_d = 1'b0;
      end
      unique case (state_q)
         StIdle: begin
            if (core.req_valid) begin
               id_d = core.req_id;
               if (orphan_q && !barrier_i) begin
                  state_d  = StWait;
                  orphan_d = 1'b0;
               end else begin
                  state_d = StArrive;
               end
            end
         end
         StArrive: begin
            state_d = StWait;
         end
         StWait: begin
            if (barrier_i) begin
               err_d   = 1'b0;
               data_d  = epoch_d;
               state_d = StResp;
            end else if (timeout_hit) begin
               err_d    = 1'b1;
               data_d   = epoch_q;
               orphan_d = 1'b1;
               state_d  = StResp;
            end else if (TimeoutCycles != 0) begin
               timer_d = (timer_q == '1) ? timer_q : timer_q + 1'b1;
            end
         end
         StResp: begin
            if (core.rsp_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Outputs decoded from state; response fields forced low outside RESP
   always_comb begin
      core.req_ready = rst_ni && (state_q == StIdle);
      barrier_o      = (state_q == StArrive);
      core.rsp_valid = (state_q == StResp);
      core.rsp_id    = (state_q == StResp) ? id_q : '0;
      core.rsp_data  = (state_q == StResp) ? data_q : '0;
      core.rsp_error = (state_q == StResp) && err_q;
   end

endmodule
